// File: rtl/axi4_lite_reg_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, address
// regions and the decoded register selector.
package axi4_lite_reg_pkg;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  localparam int IDX_W = 4;

  typedef logic [IDX_W-1:0] reg_index_t;

  typedef enum logic [1:0] {
    REG_CTRL,
    REG_STAT_LO,
    REG_STAT_HI,
    REG_NONE
  } reg_region_t;

  typedef struct packed {
    reg_region_t region;
    reg_index_t  index;
  } reg_decode_t;

  typedef enum logic {
    CH_IDLE,
    CH_DONE
  } chan_state_t;

endpackage

// File: rtl/axi4_lite_reg_decode.sv
// Combinational byte-address to register-region decoder. Control words come
// first, then interleaved lo/hi word pairs of each status input.
module axi4_lite_reg_decode
  import axi4_lite_reg_pkg::*;
#(
  parameter int addr_width = 7,
  parameter int num_ctrl   = 4,
  parameter int num_stat   = 4
) (
  input  logic [addr_width-1:0] addr,
  output reg_decode_t           decode
);

  localparam logic [31:0] CTRL_END = 32'(num_ctrl);
  localparam logic [31:0] STAT_END = 32'(num_ctrl + 2 * num_stat);

  logic [31:0] word;
  logic [31:0] offset;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    word          = 32'(addr[addr_width-1:2]);
    offset        = word - CTRL_END;
    decode.region = REG_NONE;
    decode.index  = '0;
    if (word < CTRL_END) begin
      decode.region = REG_CTRL;
      decode.index  = reg_index_t'(word);
    end else if (word < STAT_END) begin
      // Even offsets are the low word of a pair, odd offsets the high word.
      decode.region = offset[0] ? REG_STAT_HI : REG_STAT_LO;
      decode.index  = reg_index_t'(offset >> 1);
    end
  end

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// Register bank behind the AXI4-Lite front end: RW control registers plus
// read-only 64-bit status inputs with a hi-word snapshot for coherent reads.
module axi4_lite_reg_bank
  import axi4_lite_reg_pkg::*;
#(
  parameter int addr_width = 7,
  parameter int num_ctrl   = 4,
  parameter int num_stat   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_req,
  input  logic [addr_width-1:0]      write_addr,
  input  logic [31:0]                write_value,
  input  logic [3:0]                 write_mask,
  output logic                       write_ready,
  output logic                       write_response,
  input  logic                       read_req,
  input  logic [addr_width-1:0]      read_addr,
  output logic                       read_ready,
  output logic                       read_response,
  output logic [31:0]                read_value,
  output logic [32*num_ctrl-1:0]     ctrl_out,
  output logic [num_ctrl-1:0]        ctrl_wr_pulse,
  input  logic [64*num_stat-1:0]     stat_in
);

  localparam int NS = (num_stat > 0) ? num_stat : 1;

  if (num_ctrl < 1 || num_ctrl > 16 || num_stat < 0 || num_stat > 16 ||
      4 * (num_ctrl + 2 * num_stat) > 2 ** addr_width) begin : g_param_err
    $error("axi4_lite_reg_bank: register map does not fit the parameters");
  end

  reg_decode_t wr_dec;
  reg_decode_t rd_dec;

  axi4_lite_reg_decode #(
    .addr_width(addr_width), .num_ctrl(num_ctrl), .num_stat(num_stat)
  ) u_wr_decode (
    .addr  (write_addr),
    .decode(wr_dec)
  );

  axi4_lite_reg_decode #(
    .addr_width(addr_width), .num_ctrl(num_ctrl), .num_stat(num_stat)
  ) u_rd_decode (
    .addr  (read_addr),
    .decode(rd_dec)
  );

  chan_state_t         wr_state_reg, wr_state_next;
  chan_state_t         rd_state_reg, rd_state_next;
  logic                rd_accept;
  logic                wr_resp_reg, wr_resp_next;
  logic                rd_resp_reg, rd_resp_next;
  logic [31:0]         rd_value_reg, rd_value_next;
  logic [num_ctrl-1:0] wr_pulse_reg, wr_pulse_next;
  logic [31:0]         ctrl_reg   [num_ctrl];
  logic [31:0]         shadow_reg [NS];

  // Write channel: a request seen in IDLE is committed on that same edge.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_resp_next  = wr_resp_reg;
    wr_pulse_next = '0;
    case (wr_state_reg)
      CH_IDLE: begin
        if (write_req) begin
          wr_state_next = CH_DONE;
          wr_resp_next  = (wr_dec.region == REG_CTRL) ? RESP_OKAY : RESP_SLVERR;
          for (int i = 0; i < num_ctrl; i++) begin
            if (wr_dec.region == REG_CTRL && wr_dec.index == reg_index_t'(i)) begin
              wr_pulse_next[i] = 1'b1;
            end
          end
        end
      end
      CH_DONE: wr_state_next = CH_IDLE;
      default: wr_state_next = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= CH_IDLE;
      wr_resp_reg  <= RESP_OKAY;
      wr_pulse_reg <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_resp_reg  <= wr_resp_next;
      wr_pulse_reg <= wr_pulse_next;
    end
  end

  for (genvar gi = 0; gi < num_ctrl; gi++) begin : g_ctrl
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctrl_reg[gi] <= '0;
      end else if (wr_pulse_next[gi]) begin
        for (int b = 0; b < 4; b++) begin
          if (write_mask[b]) begin
            ctrl_reg[gi][8*b +: 8] <= write_value[8*b +: 8];
          end
        end
      end
    end
    assign ctrl_out[32*gi +: 32] = ctrl_reg[gi];
  end

  // Read channel: data is captured from pre-write register contents.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_resp_next  = rd_resp_reg;
    rd_value_next = rd_value_reg;
    rd_accept     = 1'b0;
    case (rd_state_reg)
      CH_IDLE: begin
        if (read_req) begin
          rd_state_next = CH_DONE;
          rd_accept     = 1'b1;
          rd_value_next = '0;
          rd_resp_next  = (rd_dec.region == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
          for (int i = 0; i < num_ctrl; i++) begin
            if (rd_dec.region == REG_CTRL && rd_dec.index == reg_index_t'(i)) begin
              rd_value_next = ctrl_reg[i];
            end
          end
          for (int j = 0; j < num_stat; j++) begin
            if (rd_dec.index == reg_index_t'(j)) begin
              if (rd_dec.region == REG_STAT_LO) rd_value_next = stat_in[64*j +: 32];
              if (rd_dec.region == REG_STAT_HI) rd_value_next = shadow_reg[j];
            end
          end
        end
      end
      CH_DONE: rd_state_next = CH_IDLE;
      default: rd_state_next = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= CH_IDLE;
      rd_resp_reg  <= RESP_OKAY;
      rd_value_reg <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_resp_reg  <= rd_resp_next;
      rd_value_reg <= rd_value_next;
    end
  end

  // Reading the low word freezes the high word so a lo-then-hi pair is coherent.
  for (genvar gj = 0; gj < num_stat; gj++) begin : g_shadow
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_reg[gj] <= '0;
      end else if (rd_accept && rd_dec.region == REG_STAT_LO &&
                   rd_dec.index == reg_index_t'(gj)) begin
        shadow_reg[gj] <= stat_in[64*gj+32 +: 32];
      end
    end
  end

  if (num_stat == 0) begin : g_no_stat
    assign shadow_reg[0] = '0;
  end

  assign write_ready    = (wr_state_reg == CH_DONE);
  assign write_response = wr_resp_reg;
  assign ctrl_wr_pulse  = wr_pulse_reg;
  assign read_ready     = (rd_state_reg == CH_DONE);
  assign read_response  = rd_resp_reg;
  assign read_value     = rd_value_reg;

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed self-checking bench for axi4_lite_reg_bank with default parameters.
module tb_axi4_lite_reg_bank;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         write_req = 1'b0;
  logic [6:0]   write_addr = '0;
  logic [31:0]  write_value = '0;
  logic [3:0]   write_mask = '0;
  logic         write_ready;
  logic         write_response;
  logic         read_req = 1'b0;
  logic [6:0]   read_addr = '0;
  logic         read_ready;
  logic         read_response;
  logic [31:0]  read_value;
  logic [127:0] ctrl_out;
  logic [3:0]   ctrl_wr_pulse;
  logic [255:0] stat_in = '0;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_reg_bank #(.addr_width(7), .num_ctrl(4), .num_stat(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_req     (write_req),
    .write_addr    (write_addr),
    .write_value   (write_value),
    .write_mask    (write_mask),
    .write_ready   (write_ready),
    .write_response(write_response),
    .read_req      (read_req),
    .read_addr     (read_addr),
    .read_ready    (read_ready),
    .read_response (read_response),
    .read_value    (read_value),
    .ctrl_out      (ctrl_out),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .stat_in       (stat_in)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one write, wait (bounded) for write_ready, then one idle cycle.
  task automatic do_write(input logic [6:0] a, input logic [31:0] v, input logic [3:0] m,
                          output int lat, output logic resp, output logic [3:0] pulse);
    write_addr  = a;
    write_value = v;
    write_mask  = m;
    write_req   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!write_ready && lat < 8);
    resp  = write_response;
    pulse = ctrl_wr_pulse;
    write_req = 1'b0;
    $display("write addr=0x%02h value=0x%08h mask=%b lat=%0d resp=%0b pulse=%b",
             a, v, m, lat, resp, pulse);
    @(posedge clk); #1;
    check_eq("wr_ready_drop", 64'(write_ready), 64'd0);
    check_eq("wr_pulse_drop", 64'(ctrl_wr_pulse), 64'd0);
  endtask

  task automatic do_read(input logic [6:0] a, output int lat, output logic resp,
                         output logic [31:0] val);
    read_addr = a;
    read_req  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!read_ready && lat < 8);
    resp = read_response;
    val  = read_value;
    read_req = 1'b0;
    $display("read  addr=0x%02h lat=%0d resp=%0b value=0x%08h", a, lat, resp, val);
    @(posedge clk); #1;
    check_eq("rd_ready_drop", 64'(read_ready), 64'd0);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] exp_value;
    logic        exp_resp;
  } rd_vec_t;

  initial begin
    int          lat;
    logic        resp;
    logic [3:0]  pulse;
    logic [31:0] val;
    logic [5:0]  pattern;
    int          ready_cnt;
    rd_vec_t     stat_vecs [8];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_write_ready", 64'(write_ready), 64'd0);
    check_eq("rst_read_ready", 64'(read_ready), 64'd0);
    check_eq("rst_read_value", 64'(read_value), 64'd0);
    check_eq("rst_ctrl_out_lo", ctrl_out[63:0], 64'd0);
    check_eq("rst_ctrl_out_hi", ctrl_out[127:64], 64'd0);
    check_eq("rst_pulse", 64'(ctrl_wr_pulse), 64'd0);
    check_eq("rst_resps", 64'({write_response, read_response}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Masked control write
    do_write(7'h04, 32'hDEADBEEF, 4'b0101, lat, resp, pulse);
    check_eq("wr1_latency", 64'(lat), 64'd1);
    check_eq("wr1_resp", 64'(resp), 64'd0);
    check_eq("wr1_pulse", 64'(pulse), 64'b0010);
    check_eq("wr1_reg1", 64'(ctrl_out[63:32]), 64'h00AD00EF);
    check_eq("wr1_reg0", 64'(ctrl_out[31:0]), 64'd0);
    check_eq("wr1_reg23", ctrl_out[127:64], 64'd0);

    // Status reads with hi snapshot
    stat_in[63:0]    = 64'h11111111_22222222;
    stat_in[127:64]  = 64'hAAAABBBB_CCCCDDDD;
    stat_in[255:192] = 64'h01234567_89ABCDEF;
    do_read(7'h10, lat, resp, val);
    check_eq("rd_lat", 64'(lat), 64'd1);
    check_eq("stat0_lo", 64'(val), 64'h22222222);
    check_eq("stat0_lo_resp", 64'(resp), 64'd0);
    stat_in[63:0] = 64'h33333333_44444444;
    do_read(7'h14, lat, resp, val);
    check_eq("stat0_hi_shadow", 64'(val), 64'h11111111);
    check_eq("stat0_hi_resp", 64'(resp), 64'd0);

    stat_vecs[0] = '{7'h10, 32'h44444444, 1'b0};
    stat_vecs[1] = '{7'h14, 32'h33333333, 1'b0};
    stat_vecs[2] = '{7'h18, 32'hCCCCDDDD, 1'b0};
    stat_vecs[3] = '{7'h1C, 32'hAAAABBBB, 1'b0};
    stat_vecs[4] = '{7'h2C, 32'h00000000, 1'b0};
    stat_vecs[5] = '{7'h2B, 32'h89ABCDEF, 1'b0};
    stat_vecs[6] = '{7'h2C, 32'h01234567, 1'b0};
    stat_vecs[7] = '{7'h30, 32'h00000000, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_read(stat_vecs[i].addr, lat, resp, val);
      check_eq($sformatf("statvec%0d_value", i), 64'(val), 64'(stat_vecs[i].exp_value));
      check_eq($sformatf("statvec%0d_resp", i), 64'(resp), 64'(stat_vecs[i].exp_resp));
    end

    // Unmapped and read-only accesses
    do_read(7'h7C, lat, resp, val);
    check_eq("none_rd_value", 64'(val), 64'd0);
    check_eq("none_rd_resp", 64'(resp), 64'd1);
    do_write(7'h10, 32'hFFFFFFFF, 4'hF, lat, resp, pulse);
    check_eq("stat_wr_resp", 64'(resp), 64'd1);
    check_eq("stat_wr_pulse", 64'(pulse), 64'd0);
    check_eq("stat_wr_ctrl", ctrl_out[63:0], 64'h00AD00EF_00000000);
    do_write(7'h30, 32'hFFFFFFFF, 4'hF, lat, resp, pulse);
    check_eq("none_wr_resp", 64'(resp), 64'd1);
    check_eq("none_wr_ctrl", ctrl_out[127:64], 64'd0);

    // Zero-mask write still pulses
    do_write(7'h0C, 32'hFFFFFFFF, 4'b0000, lat, resp, pulse);
    check_eq("mask0_pulse", 64'(pulse), 64'b1000);
    check_eq("mask0_reg3", 64'(ctrl_out[127:96]), 64'd0);

    // Same-cycle write and read of reg0
    write_addr = 7'h00; write_value = 32'hA5A5A5A5; write_mask = 4'hF; write_req = 1'b1;
    read_addr  = 7'h00; read_req = 1'b1;
    @(posedge clk); #1;
    $display("same-cycle wr/rd reg0: wr_ready=%0b rd_ready=%0b read_value=0x%08h",
             write_ready, read_ready, read_value);
    check_eq("same_wr_ready", 64'(write_ready), 64'd1);
    check_eq("same_rd_ready", 64'(read_ready), 64'd1);
    check_eq("same_rd_old", 64'(read_value), 64'd0);
    check_eq("same_reg0_new", 64'(ctrl_out[31:0]), 64'hA5A5A5A5);
    write_req = 1'b0; read_req = 1'b0;
    @(posedge clk); #1;
    do_read(7'h00, lat, resp, val);
    check_eq("reread_reg0", 64'(val), 64'hA5A5A5A5);

    // Held read_req: three back-to-back reads in six cycles
    read_addr = 7'h04; read_req = 1'b1;
    pattern = '0; ready_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pattern = {pattern[4:0], read_ready};
      if (read_ready) begin
        ready_cnt++;
        $display("held read %0d: value=0x%08h", ready_cnt, read_value);
        check_eq("held_rd_value", 64'(read_value), 64'h00AD00EF);
      end
      if (k == 4) read_req = 1'b0;
    end
    check_eq("held_pattern", 64'(pattern), 64'b101010);
    check_eq("held_count", 64'(ready_cnt), 64'd3);

    // Reset while a write is in DONE, with the request held through reset
    do_write(7'h08, 32'hFFFFFFFF, 4'hF, lat, resp, pulse);
    check_eq("pre_rst_reg2", 64'(ctrl_out[95:64]), 64'hFFFFFFFF);
    write_addr = 7'h08; write_value = 32'h12345678; write_mask = 4'b0011; write_req = 1'b1;
    @(posedge clk); #1;
    check_eq("pend_ready", 64'(write_ready), 64'd1);
    check_eq("pend_reg2", 64'(ctrl_out[95:64]), 64'hFFFF5678);
    rst = 1'b1;
    #1;
    $display("reset asserted mid-write: wr_ready=%0b ctrl_out=0x%032h", write_ready, ctrl_out);
    check_eq("midrst_ready", 64'(write_ready), 64'd0);
    check_eq("midrst_pulse", 64'(ctrl_wr_pulse), 64'd0);
    check_eq("midrst_ctrl_lo", ctrl_out[63:0], 64'd0);
    check_eq("midrst_ctrl_hi", ctrl_out[127:64], 64'd0);
    check_eq("midrst_rd_value", 64'(read_value), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!write_ready && lat < 8);
    pulse = ctrl_wr_pulse;
    write_req = 1'b0;
    $display("post-reset write: lat=%0d pulse=%b reg2=0x%08h", lat, pulse, ctrl_out[95:64]);
    check_eq("postrst_lat", 64'(lat), 64'd1);
    check_eq("postrst_pulse", 64'(pulse), 64'b0100);
    check_eq("postrst_reg2", 64'(ctrl_out[95:64]), 64'h00005678);
    ready_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (write_ready) ready_cnt++;
    end
    check_eq("postrst_extra_ready", 64'(ready_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
